truth_table_sequencer: RTL and testbench

//  Sequences the five 3-input boolean function units (fxyz A..E). It drives x,y,z through all
//  8 combinations, samples the selected unit's output and assembles an 8-bit truth table.
//  It also compares the result against an expected table. Sits between a host/testbench and
//  the function datapath. It replaces the hand-written #1 stimulus lists with a clocked,

---
 rtl/truth_table_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_truth_table_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer
//   Sweeps x,y,z through all eight input combinations, samples the selected
//   3-input function unit on fn_s and assembles its 8-entry truth table.
//   It can target a single function, or sweep every function in turn
//   (sel = 3'b111). In single-function mode the table is compared against
//   'expected'.
//
// Ports
//   clk, rst_n    rising-edge clock, synchronous active-low reset
//   start, abort  sweep request / cancel
//   sel           function index, or 3'b111 for all functions
//   expected      reference table for the single-function compare
//   fn_s          outputs of the function units (bit k = function k)
//   x, y, z       stimulus driven to every function unit
//   busy          sweep in progress
//   tbl, tbl_fn   captured table (bit i = f at {x,y,z}=i) and its function
//   tbl_valid     one-cycle pulse, tbl is complete for tbl_fn
//   match         tbl == expected, updated with done, held until next start
//   done          one-cycle pulse at the end of the whole sweep
//   err           one-cycle pulse, start seen with an illegal sel
//   dbg_state     current FSM state
//
// Handshake: start is a request that is accepted only while the block is
// idle (busy=0 and not in the final DONE cycle); once accepted busy stays
// high until the last table is captured. Requests while busy are dropped.

module truth_table_sequencer #(
  parameter int N_FUNC = 5,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [2:0]        sel,
  input  logic [7:0]        expected,
  input  logic [N_FUNC-1:0] fn_s,
  output logic              x,
  output logic              y,
  output logic              z,
  output logic              busy,
  output logic [7:0]        tbl,
  output logic [2:0]        tbl_fn,
  output logic              tbl_valid,
  output logic              match,
  output logic              done,
  output logic              err,
  output logic [2:0]        dbg_state
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_SAMPLE = 3'd2,
    S_NEXTFN = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // With no settle time the DRIVE state is skipped entirely.
  localparam state_t S_COMBO = (SETTLE == 0) ? S_SAMPLE : S_DRIVE;

  state_t          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [2:0]      fn_q, fn_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      sel_q, sel_d;
  logic [7:0]      exp_q, exp_d;
  logic [2:0]      xyz_q, xyz_d;
  logic            busy_q, busy_d;
  logic [7:0]      tbl_q, tbl_d;
  logic [2:0]      tbl_fn_q, tbl_fn_d;
  logic            tbl_valid_q, tbl_valid_d;
  logic            match_q, match_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  // Pad fn_s to 8 bits so any 3-bit index stays in range.
  logic [7:0] fn_ext;
  assign fn_ext = {{(8 - N_FUNC){1'b0}}, fn_s};

  logic sel_legal;
  assign sel_legal = (sel == 3'd7) || (int'(sel) < N_FUNC);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    fn_d        = fn_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    exp_d       = exp_q;
    xyz_d       = xyz_q;
    busy_d      = busy_q;
    tbl_d       = tbl_q;
    tbl_fn_d    = tbl_fn_q;
    tbl_valid_d = 1'b0;
    match_d     = match_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (sel_legal) begin
            sel_d   = sel;
            exp_d   = expected;
            idx_d   = 3'd0;
            fn_d    = (sel == 3'd7) ? 3'd0 : sel;
            cnt_d   = '0;
            xyz_d   = 3'd0;
            tbl_d   = 8'd0;
            busy_d  = 1'b1;
            match_d = 1'b0;
            state_d = S_COMBO;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_DRIVE: begin
        if (int'(cnt_q) == SETTLE - 1) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_SAMPLE: begin
        tbl_d[idx_q] = fn_ext[fn_q];
        if (idx_q != 3'd7) begin
          idx_d   = idx_q + 3'd1;
          xyz_d   = idx_q + 3'd1;
          cnt_d   = '0;
          state_d = S_COMBO;
        end else begin
          tbl_valid_d = 1'b1;
          tbl_fn_d    = fn_q;
          if ((sel_q == 3'd7) && (int'(fn_q) < N_FUNC - 1)) begin
            state_d = S_NEXTFN;
          end else begin
            // Last table captured: the sweep is over, release the bus.
            busy_d  = 1'b0;
            xyz_d   = 3'd0;
            state_d = S_DONE;
          end
        end
      end

      S_NEXTFN: begin
        fn_d    = fn_q + 3'd1;
        idx_d   = 3'd0;
        xyz_d   = 3'd0;
        cnt_d   = '0;
        tbl_d   = 8'd0;
        state_d = S_COMBO;
      end

      S_DONE: begin
        done_d  = 1'b1;
        match_d = (sel_q != 3'd7) && (tbl_q == exp_q);
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Abort cancels any active sweep and discards this cycle's work;
    // the partially built table is left visible.
    if (abort && ((state_q == S_DRIVE) || (state_q == S_SAMPLE) ||
                  (state_q == S_NEXTFN))) begin
      state_d     = S_IDLE;
      busy_d      = 1'b0;
      xyz_d       = 3'd0;
      tbl_d       = tbl_q;
      tbl_fn_d    = tbl_fn_q;
      tbl_valid_d = 1'b0;
      idx_d       = idx_q;
      fn_d        = fn_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= 3'd0;
      fn_q        <= 3'd0;
      cnt_q       <= '0;
      sel_q       <= 3'd0;
      exp_q       <= 8'd0;
      xyz_q       <= 3'd0;
      busy_q      <= 1'b0;
      tbl_q       <= 8'd0;
      tbl_fn_q    <= 3'd0;
      tbl_valid_q <= 1'b0;
      match_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      fn_q        <= fn_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      exp_q       <= exp_d;
      xyz_q       <= xyz_d;
      busy_q      <= busy_d;
      tbl_q       <= tbl_d;
      tbl_fn_q    <= tbl_fn_d;
      tbl_valid_q <= tbl_valid_d;
      match_q     <= match_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign x         = xyz_q[2];
  assign y         = xyz_q[1];
  assign z         = xyz_q[0];
  assign busy      = busy_q;
  assign tbl       = tbl_q;
  assign tbl_fn    = tbl_fn_q;
  assign tbl_valid = tbl_valid_q;
  assign match     = match_q;
  assign done      = done_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench for truth_table_sequencer: one instance with SETTLE=1 and a
// second with SETTLE=0. Function units A..E are modelled here; every
// expected table and cycle count below is hand-computed.

module tb_truth_table_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, start0, abort;
  logic [2:0] sel;
  logic [7:0] expected;

  logic [4:0] fn_s, fn_s0;
  logic       x, y, z, busy, tbl_valid, match, done, err;
  logic [7:0] tbl;
  logic [2:0] tbl_fn, dbg_state;
  logic       x0, y0, z0, busy0, tbl_valid0, match0, done0, err0;
  logic [7:0] tbl0;
  logic [2:0] tbl_fn0, dbg_state0;

  // A: ~x&y&~z  B: x&y&z  C: ~z&(~x|y)  D: z&(x|~y)  E: y|(~x&~z)
  function automatic logic [4:0] f_units(input logic a, input logic b, input logic c);
    f_units[0] = ~a & b & ~c;
    f_units[1] = a & b & c;
    f_units[2] = ~c & (~a | b);
    f_units[3] = c & (a | ~b);
    f_units[4] = b | (~a & ~c);
  endfunction

  always_comb fn_s  = f_units(x, y, z);
  always_comb fn_s0 = f_units(x0, y0, z0);

  truth_table_sequencer #(.N_FUNC(5), .SETTLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .sel(sel),
    .expected(expected), .fn_s(fn_s), .x(x), .y(y), .z(z), .busy(busy),
    .tbl(tbl), .tbl_fn(tbl_fn), .tbl_valid(tbl_valid), .match(match),
    .done(done), .err(err), .dbg_state(dbg_state)
  );

  truth_table_sequencer #(.N_FUNC(5), .SETTLE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort), .sel(sel),
    .expected(expected), .fn_s(fn_s0), .x(x0), .y(y0), .z(z0), .busy(busy0),
    .tbl(tbl0), .tbl_fn(tbl_fn0), .tbl_valid(tbl_valid0), .match(match0),
    .done(done0), .err(err0), .dbg_state(dbg_state0)
  );

  // ---------------- scoreboard ----------------
  logic [10:0] exp_q[$];   // {tbl_fn, tbl} in expected order
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse start for one edge; returns at the negedge after the start edge.
  task automatic start_sweep(input logic [2:0] s, input logic [7:0] e, input logic ab);
    sel = s; expected = e; start = 1'b1; abort = ab;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
  endtask

  int busy_n, tv_at, done_at, done_n, extra_tv, timed_out;
  logic [2:0] done_xyz, ab_xyz;
  logic done_busy, done_match, ab_busy;

  // Observe one sweep sample by sample (k=0 is the cycle after the start
  // edge). Optionally pokes a stray start at poke_at and aborts at abort_at.
  task automatic run_sweep(input int max_cyc, input int poke_at, input int abort_at);
    busy_n = 0; tv_at = -1; done_at = -1; done_n = 0; extra_tv = 0; timed_out = 1;
    for (int k = 0; k < max_cyc; k++) begin
      if (busy) busy_n++;
      if (tbl_valid) begin
        tv_at = k;
        if (exp_q.size() == 0) extra_tv++;
        else chk("tbl_pair", {21'd0, tbl_fn, tbl}, {21'd0, exp_q.pop_front()});
      end
      if (done) begin
        done_n++; done_at = k; done_xyz = {x, y, z};
        done_busy = busy; done_match = match; timed_out = 0;
        break;
      end
      if ((abort_at >= 0) && (k == abort_at + 1)) begin
        abort = 1'b0; ab_busy = busy; ab_xyz = {x, y, z};
      end
      if (k == poke_at) begin start = 1'b1; sel = 3'd2; end
      else start = 1'b0;
      if (k == abort_at) abort = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    if (abort_at < 0) chk("sweep_timeout", timed_out, 0);
    chk("no_extra_tbl_valid", extra_tv, 0);
    chk("scoreboard_drained", exp_q.size(), 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0; start = 1'b0; start0 = 1'b0; abort = 1'b0;
    sel = 3'd0; expected = 8'd0;
    tick(3);
    chk("rst_xyz", {x, y, z}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tbl", tbl, 0);
    chk("rst_tbl_fn", tbl_fn, 0);
    chk("rst_flags", {tbl_valid, match, done, err}, 0);
    chk("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    tick(1);

    // 1: single function A
    exp_q.push_back({3'd0, 8'h04});
    start_sweep(3'd0, 8'h04, 1'b0);
    run_sweep(40, -1, -1);
    chk("t1_busy_cycles", busy_n, 16);
    chk("t1_tv_at", tv_at, 16);
    chk("t1_done_at", done_at, 17);
    chk("t1_done_busy", done_busy, 0);
    chk("t1_done_xyz", done_xyz, 0);
    chk("t1_match", done_match, 1);
    tick(1);
    chk("t1_done_pulse", done, 0);
    chk("t1_match_held", match, 1);
    chk("t1_tbl_held", tbl, 8'h04);

    // 2: sweep all functions
    exp_q.push_back({3'd0, 8'h04});
    exp_q.push_back({3'd1, 8'h80});
    exp_q.push_back({3'd2, 8'h45});
    exp_q.push_back({3'd3, 8'hA2});
    exp_q.push_back({3'd4, 8'hCD});
    start_sweep(3'd7, 8'hCD, 1'b0);
    run_sweep(120, -1, -1);
    chk("t2_busy_cycles", busy_n, 84);
    chk("t2_done_at", done_at, 85);
    chk("t2_match_all", done_match, 0);
    tick(1);
    chk("t2_single_done", done, 0);

    // 3: compare, with sel/expected changed after start
    exp_q.push_back({3'd4, 8'hCD});
    start_sweep(3'd4, 8'hCD, 1'b0);
    expected = 8'hCC; sel = 3'd0;
    run_sweep(40, -1, -1);
    chk("t3_match_hit", done_match, 1);
    chk("t3_done_at", done_at, 17);
    exp_q.push_back({3'd4, 8'hCD});
    start_sweep(3'd4, 8'hCC, 1'b0);
    run_sweep(40, -1, -1);
    chk("t3_match_miss", done_match, 0);

    // 4: illegal sel, then start while busy
    start_sweep(3'd5, 8'h00, 1'b0);
    chk("t4_err_sel5", err, 1);
    chk("t4_busy_sel5", busy, 0);
    tick(1);
    chk("t4_err_pulse", err, 0);
    start_sweep(3'd6, 8'h00, 1'b0);
    chk("t4_err_sel6", err, 1);
    tick(1);
    exp_q.push_back({3'd1, 8'h80});
    start_sweep(3'd1, 8'h80, 1'b0);
    run_sweep(40, 5, -1);
    chk("t4_busy_cycles", busy_n, 16);
    chk("t4_done_at", done_at, 17);
    chk("t4_match", done_match, 1);
    chk("t4_no_err", err, 0);

    // 5: abort while idx=3 is being driven
    tick(1);
    start_sweep(3'd4, 8'hCD, 1'b0);
    run_sweep(30, -1, 6);
    chk("t5_abort_busy", ab_busy, 0);
    chk("t5_abort_xyz", ab_xyz, 0);
    chk("t5_no_done", done_n, 0);
    chk("t5_partial_tbl", tbl, 8'h05);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    tick(1);
    chk("t5_idle_abort_tbl", tbl, 8'h05);
    chk("t5_idle_abort_state", dbg_state, 0);
    exp_q.push_back({3'd0, 8'h04});
    start_sweep(3'd0, 8'h04, 1'b1);
    chk("t5_start_beats_abort", busy, 1);
    run_sweep(40, -1, -1);
    chk("t5_sweep_done_at", done_at, 17);

    // 6: reset mid-sweep, then a full clean sweep
    tick(1);
    start_sweep(3'd7, 8'h00, 1'b0);
    tick(40);
    chk("t6_pre_tbl_fn", tbl_fn, 1);
    chk("t6_pre_tbl", tbl, 8'h05);
    rst_n = 1'b0; start = 1'b1; abort = 1'b1; sel = 3'd0;
    tick(1);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_xyz", {x, y, z}, 0);
    chk("t6_rst_tbl", tbl, 0);
    chk("t6_rst_tbl_fn", tbl_fn, 0);
    chk("t6_rst_state", dbg_state, 0);
    rst_n = 1'b1; start = 1'b0; abort = 1'b0;
    tick(1);
    exp_q.push_back({3'd0, 8'h04});
    exp_q.push_back({3'd1, 8'h80});
    exp_q.push_back({3'd2, 8'h45});
    exp_q.push_back({3'd3, 8'hA2});
    exp_q.push_back({3'd4, 8'hCD});
    start_sweep(3'd7, 8'h00, 1'b0);
    run_sweep(120, -1, -1);
    chk("t6_done_at", done_at, 85);

    // SETTLE=0 instance: function D, no DRIVE cycles
    tick(1);
    sel = 3'd3; expected = 8'hA2; start0 = 1'b1;
    tick(1);
    start0 = 1'b0;
    busy_n = 0; tv_at = -1; done_at = -1;
    for (int k = 0; k < 30; k++) begin
      if (busy0) busy_n++;
      if (tbl_valid0) begin
        tv_at = k;
        chk("s0_tbl_pair", {tbl_fn0, tbl0}, {3'd3, 8'hA2});
      end
      if (done0) begin
        done_at = k;
        chk("s0_match", match0, 1);
        break;
      end
      tick(1);
    end
    chk("s0_busy_cycles", busy_n, 8);
    chk("s0_tv_at", tv_at, 8);
    chk("s0_done_at", done_at, 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
